// File: rtl/piso_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_serial_tx_pkg
// Brief    : Shared state encodings and counter-width helpers for the PISO tx.
// Revision : 1.0
// ============================================================================
package piso_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Counters never shrink below one bit, even for a count of 1.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serial_tx_bit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : bit_tick_gen
// Brief    : Bit-period divider; tick marks the last enabled cycle of a period.
// Revision : 1.0
// ============================================================================
module bit_tick_gen
    import piso_serial_tx_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic Ce,
    input  logic run,
    output logic tick
);

    localparam int              c_dw   = cnt_width(DIV);
    localparam logic [c_dw-1:0] c_last = c_dw'(DIV - 1);

    logic [c_dw-1:0] div_q;
    logic [c_dw-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (!run) begin
            div_d = '0;
        end else if (div_q == c_last) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q <= '0;
        end else if (Ce) begin
            div_q <= div_d;
        end
    end

    assign tick = run && (div_q == c_last);

endmodule
`default_nettype wire

// File: rtl/piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_serial_tx
// Brief    : Parallel-in/serial-out transmitter with Load/Ready handshake,
//            per-bit capture strobe (Vout) and end-of-word Done pulse.
// Revision : 1.0
// ============================================================================
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Ce,
    input  logic             Load,
    input  logic [WIDTH-1:0] Pdata,
    output logic             Ready,
    output logic             Qout,
    output logic             Vout,
    output logic             Done
);

    localparam int              c_cw       = cnt_width(WIDTH);
    localparam logic [c_cw-1:0] c_last_bit = c_cw'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [c_cw-1:0]  bit_cnt_q, bit_cnt_d;
    logic             ready_q, ready_d;
    logic             qout_q, qout_d;
    logic             done_q, done_d;
    logic             w_run;
    logic             w_tick;

    assign w_run = (state_q == ST_SHIFT);

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .Ce   (Ce),
        .run  (w_run),
        .tick (w_tick)
    );

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        ready_d   = ready_q;
        qout_d    = qout_q;
        done_d    = done_q;
        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    state_d   = ST_SHIFT;
                    sreg_d    = Pdata;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    qout_d    = (MSB_FIRST != 0) ? Pdata[WIDTH-1] : Pdata[0];
                end
            end
            ST_SHIFT: begin
                // Advance only at the edge that closes a bit period, so the
                // receiver samples Qout while it is still stable.
                if (w_tick) begin
                    sreg_d = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                              : {1'b0, sreg_q[WIDTH-1:1]};
                    if (bit_cnt_q == c_last_bit) begin
                        state_d   = ST_DONE;
                        bit_cnt_d = '0;
                        qout_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        qout_d    = (MSB_FIRST != 0) ? sreg_q[WIDTH-2] : sreg_q[1];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                qout_d  = 1'b0;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b1;
            qout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (Ce) begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            ready_q   <= ready_d;
            qout_q    <= qout_d;
            done_q    <= done_d;
        end
    end

    assign Ready = ready_q;
    assign Qout  = qout_q;
    assign Vout  = w_tick;
    assign Done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serial_tx
// Brief    : Directed self-checking bench: MSB-first DIV=2 and LSB-first DIV=1
//            transmitters, with a Ce-gated shift-in receiver on the first.
// Revision : 1.0
// ============================================================================
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       load,  load2;
    logic [7:0] pdata, pdata2;
    logic       ready, qout, vout, done;
    logic       ready2, qout2, vout2, done2;
    logic [7:0] rx_sr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(1)) u_dut (
        .CLK   (clk),
        .RST   (rst),
        .Ce    (ce),
        .Load  (load),
        .Pdata (pdata),
        .Ready (ready),
        .Qout  (qout),
        .Vout  (vout),
        .Done  (done)
    );

    piso_serial_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u_dut_lsb (
        .CLK   (clk),
        .RST   (rst),
        .Ce    (ce),
        .Load  (load2),
        .Pdata (pdata2),
        .Ready (ready2),
        .Qout  (qout2),
        .Vout  (vout2),
        .Done  (done2)
    );

    // Downstream receiver: Vout is the capture enable of a shift-in register.
    always_ff @(posedge clk) begin
        if (ce && vout) begin
            rx_sr <= {rx_sr[6:0], qout};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit lsb_inst,
                              input logic eq, input logic ev, input logic ed, input logic er);
        check({tag, ".qout"},  32'(lsb_inst ? qout2  : qout),  32'(eq));
        check({tag, ".vout"},  32'(lsb_inst ? vout2  : vout),  32'(ev));
        check({tag, ".done"},  32'(lsb_inst ? done2  : done),  32'(ed));
        check({tag, ".ready"}, 32'(lsb_inst ? ready2 : ready), 32'(er));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where
    // Ready is back to 1.
    task automatic run_word(input bit lsb_inst, input logic [7:0] data,
                            input bit keep_load, input logic [7:0] next_data,
                            input int stall_at);
        int   div;
        int   idx;
        logic eq, ev, ed, er;
        div = lsb_inst ? 1 : 2;
        if (lsb_inst) begin load2 = 1'b1; pdata2 = data; end
        else          begin load  = 1'b1; pdata  = data; end
        for (int k = 1; k <= 8 * div + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (lsb_inst) begin load2 = keep_load; pdata2 = next_data; end
                else          begin load  = keep_load; pdata  = next_data; end
            end
            if (k <= 8 * div) begin
                idx = (k - 1) / div;
                eq  = lsb_inst ? data[idx] : data[7 - idx];
                ev  = (((k - 1) % div) == (div - 1));
                ed  = 1'b0;
                er  = 1'b0;
            end else if (k == 8 * div + 1) begin
                eq = 1'b0; ev = 1'b0; ed = 1'b1; er = 1'b0;
            end else begin
                eq = 1'b0; ev = 1'b0; ed = 1'b0; er = 1'b1;
            end
            check_outs($sformatf("w%02h.c%0d", data, k), lsb_inst, eq, ev, ed, er);
            if (k == stall_at) begin
                ce = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check_outs($sformatf("w%02h.stall%0d", data, s), lsb_inst, eq, ev, ed, er);
                end
                ce = 1'b1;
            end
        end
        if (!lsb_inst && !keep_load) begin
            check($sformatf("rx%02h", data), 32'(rx_sr), 32'(data));
        end
    endtask

    initial begin
        int vcount;
        bit seen;
        rst = 1'b1; ce = 1'b1;
        load = 1'b0; pdata = 8'h00; load2 = 1'b0; pdata2 = 8'h00;
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_outs("reset_lsb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        run_word(1'b0, 8'hA5, 1'b0, 8'h00, 0);
        run_word(1'b1, 8'h0F, 1'b0, 8'h00, 0);

        // Load with FF held during the whole 3C word; FF accepted only afterwards.
        run_word(1'b0, 8'h3C, 1'b1, 8'hFF, 0);
        @(negedge clk);
        check("busy.accept_ready", 32'(ready), 32'd0);
        check("busy.accept_qout",  32'(qout),  32'd1);
        load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("busy.ff_complete", 32'(seen), 32'd1);
        check("rxFF", 32'(rx_sr), 32'hFF);

        // Ce stall at the start of the 3rd bit period (cycle 5 with DIV=2).
        run_word(1'b0, 8'hC3, 1'b0, 8'h00, 5);

        // Reset during bit 4 on an edge where Ce is low.
        load = 1'b1; pdata = 8'h5A;
        repeat (7) begin
            @(negedge clk);
            load = 1'b0;
        end
        check("abort.pre_qout", 32'(qout), 32'(1'b1));
        rst = 1'b1; ce = 1'b0;
        @(negedge clk);
        check_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0; ce = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vout || done) vcount++;
        end
        check("abort.no_strobes", 32'(vcount), 32'd0);

        run_word(1'b0, 8'h00, 1'b0, 8'h00, 0);
        run_word(1'b0, 8'h96, 1'b0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
